nn_cfg_bank: RTL and testbench
==============================

Name: nn_cfg_bank

Overview:
Parametrised, double-buffered configuration register bank for the NN accelerator; successor to the flat single-write config file.
- Host writes go into staging registers.
- A control-register start command commits staging to active registers in one cycle and pulses the compute engine's start.
- Adds a job FSM, a one-deep pending-start queue, abort, done interrupt, status readback and error detection.
- Sits between the host/DMA register interface and the compute/DMA engines.

Parameters:
DATA_W, 32, width of each config word
ADDR_W, 4, register address width
NUM_REGS, 8, total registers; addresses 0..NUM_REGS-2 are config words, NUM_REGS-1 is CTRL/STATUS (NUM_REGS <= 2**ADDR_W, >= 2)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_wr_en  in  1  register write strobe
i_addr  in  ADDR_W  read/write address
i_wr_data  in  DATA_W  write data
i_rd_en  in  1  register read strobe
o_rd_data  out  DATA_W  read data, valid with o_rd_valid
o_rd_valid  out  1  read data valid, 1 cycle after i_rd_en
o_cfg  out  (NUM_REGS-1)*DATA_W  active config, word k at [k*DATA_W +: DATA_W]
o_start  out  1  one-cycle job start pulse to engine
o_abort  out  1  one-cycle abort pulse to engine
i_done  in  1  engine job-complete pulse
o_busy  out  1  high in COMMIT or RUN
o_irq  out  1  done interrupt, level, sticky
o_err  out  1  sticky error flag

Behaviour:
- Reset: all staging/active regs 0, FSM IDLE, pending 0; o_rd_data, o_rd_valid, o_start, o_abort, o_busy, o_irq, o_err all 0.
- CTRL write bits:
  - [0] START
  - [1] ABORT (priority over START)
  - [2] IRQ_CLR
  - [3] ERR_CLR
  - other bits ignored
- Config write (addr < NUM_REGS-1): updates staging only, in any state. Active regs never change except in COMMIT.
- Write or read to addr >= NUM_REGS: write dropped, read returns 0, o_err set.
- Reads have 1-cycle latency:
  - config addr returns staging word.
  - CTRL addr returns status {zeros, state[1:0] at [5:4], pending [3], err [2], irq [1], busy [0]}.
- FSM states (encoding IDLE=0, COMMIT=1, RUN=2):
  - IDLE: START -> COMMIT.
  - COMMIT (1 cycle): active <= staging (pre-write value if a staging write coincides), o_irq cleared, -> RUN, with o_start=1 in the first RUN cycle.
  - RUN: i_done -> IDLE and o_irq<=1. If pending, instead -> COMMIT and pending<=0 (o_irq still set).
- START in COMMIT or RUN sets pending. START while pending already set: command dropped, o_err set.
- START and i_done in the same RUN cycle: treated as pending, so the FSM goes straight to COMMIT.
- i_done outside RUN: ignored, no error.
- ABORT from any state: FSM -> IDLE, pending cleared, active regs unchanged. o_abort pulses 1 cycle only if the state was COMMIT or RUN.
- IRQ_CLR / ERR_CLR clear the flags. A set event in the same cycle wins over the clear.
- Latency: START write cycle T -> COMMIT at T+1 -> o_start and new o_cfg at T+2.
- Reset mid-job: immediate return to reset values; no o_abort pulse.

Optional Feature:
NN_CFG_RDBK_EN.
- Defined: read port as above.
- Undefined: read logic removed; o_rd_data and o_rd_valid tied 0; out-of-range reads do not set o_err; writes unaffected.

Decomposition:
- Package nn_cfg_pkg holds:
  - FSM state encoding.
  - CTRL bit indices and STATUS field positions.
  - Config-word field offsets/widths: mode, pool, relu, stride, psum_shift, x/z/y move, img_wr_count, result scale/shift, update flags, DMA base addresses.
- Sub-module nn_cfg_decode (combinational) slices o_cfg into named engine fields, keeping the bank generic.

Test Plan:
1. Write word0=32'hC1234567 while IDLE -> o_cfg word0 stays 0. Then CTRL=1 at cycle T -> o_start high at T+2 only, o_cfg word0=32'hC1234567, o_busy=1.
2. In RUN, stage word2=32'hA0, write START, then pulse i_done -> status pending=1 before done. After done: COMMIT, second o_start, word2=32'hA0, o_irq=1.
3. Two STARTs during RUN -> pending=1, o_err=1. Write ERR_CLR -> o_err=0, FSM unaffected.
4. ABORT (CTRL=2) in RUN -> o_abort one cycle, state IDLE, o_busy=0, pending 0, o_irq unchanged. Then i_done -> no irq.
5. Write addr 9 with NUM_REGS=8 -> no reg change, o_err=1. Read addr 9 -> o_rd_data=0, o_rd_valid=1 one cycle later (RDBK_EN defined).
6. Assert i_rst during RUN -> next cycle all outputs 0, o_cfg all 0, status reads 0. START then works normally.

Source files
------------

// File: rtl/nn_cfg_pkg.sv
// Shared definitions for the NN config bank: job FSM encoding, CTRL/STATUS bit map,
// and the engine-facing field layout of the config words.
package nn_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  localparam int CTRL_START   = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_IRQ_CLR = 2;
  localparam int CTRL_ERR_CLR = 3;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_IRQ       = 1;
  localparam int STAT_ERR       = 2;
  localparam int STAT_PEND      = 3;
  localparam int STAT_STATE_LSB = 4;
  localparam int STAT_W         = 6;

  // Field placement: word index plus bit offset within that word.
  localparam int W_CTL        = 0;
  localparam int OFF_MODE     = 0;
  localparam int OFF_POOL     = 2;
  localparam int OFF_RELU     = 3;
  localparam int OFF_STRIDE   = 4;
  localparam int OFF_PSUM_SH  = 8;
  localparam int W_MOVE       = 1;
  localparam int OFF_X_MOVE   = 0;
  localparam int OFF_Z_MOVE   = 8;
  localparam int OFF_Y_MOVE   = 16;
  localparam int W_RES        = 2;
  localparam int OFF_IMG_WR   = 0;
  localparam int OFF_RES_SCL  = 16;
  localparam int OFF_RES_SH   = 24;
  localparam int OFF_UPD      = 29;
  localparam int W_DMA_SRC    = 3;
  localparam int W_DMA_DST    = 4;

  typedef struct packed {
    logic [1:0]  mode;
    logic        pool;
    logic        relu;
    logic [3:0]  stride;
    logic [4:0]  psum_shift;
    logic [7:0]  x_move;
    logic [7:0]  z_move;
    logic [7:0]  y_move;
    logic [15:0] img_wr_count;
    logic [7:0]  result_scale;
    logic [4:0]  result_shift;
    logic [2:0]  upd_flags;
    logic [31:0] dma_src_base;
    logic [31:0] dma_dst_base;
  } nn_cfg_fields_t;

  localparam int FIELDS_W = $bits(nn_cfg_fields_t);

  function automatic logic [STAT_W-1:0] pack_status(state_e st, logic pend, logic err,
                                                    logic irq, logic busy);
    logic [STAT_W-1:0] s;
    s = '0;
    s[STAT_STATE_LSB +: 2] = st;
    s[STAT_PEND]           = pend;
    s[STAT_ERR]            = err;
    s[STAT_IRQ]            = irq;
    s[STAT_BUSY]           = busy;
    return s;
  endfunction

endpackage

// File: rtl/nn_cfg_decode.sv
// Slices the flat active-config vector into named engine fields so the bank itself
// stays layout-agnostic. Words missing from a small bank decode as zero.
module nn_cfg_decode
  import nn_cfg_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_CFG = 7
) (
  input  logic [NUM_CFG*DATA_W-1:0] i_cfg,
  output logic [FIELDS_W-1:0]       o_fields
);

  localparam int NEED_W = W_DMA_DST * DATA_W + 32;
  localparam int EXT_W  = (NUM_CFG * DATA_W > NEED_W) ? NUM_CFG * DATA_W : NEED_W;

  logic [EXT_W-1:0] cfg_ext;
  logic             unused_cfg_bits;
  nn_cfg_fields_t   f;

  assign cfg_ext         = EXT_W'(i_cfg);
  assign unused_cfg_bits = ^cfg_ext;

  always_comb begin
    f              = '0;
    f.mode         = cfg_ext[W_CTL*DATA_W + OFF_MODE +: 2];
    f.pool         = cfg_ext[W_CTL*DATA_W + OFF_POOL];
    f.relu         = cfg_ext[W_CTL*DATA_W + OFF_RELU];
    f.stride       = cfg_ext[W_CTL*DATA_W + OFF_STRIDE +: 4];
    f.psum_shift   = cfg_ext[W_CTL*DATA_W + OFF_PSUM_SH +: 5];
    f.x_move       = cfg_ext[W_MOVE*DATA_W + OFF_X_MOVE +: 8];
    f.z_move       = cfg_ext[W_MOVE*DATA_W + OFF_Z_MOVE +: 8];
    f.y_move       = cfg_ext[W_MOVE*DATA_W + OFF_Y_MOVE +: 8];
    f.img_wr_count = cfg_ext[W_RES*DATA_W + OFF_IMG_WR +: 16];
    f.result_scale = cfg_ext[W_RES*DATA_W + OFF_RES_SCL +: 8];
    f.result_shift = cfg_ext[W_RES*DATA_W + OFF_RES_SH +: 5];
    f.upd_flags    = cfg_ext[W_RES*DATA_W + OFF_UPD +: 3];
    f.dma_src_base = cfg_ext[W_DMA_SRC*DATA_W +: 32];
    f.dma_dst_base = cfg_ext[W_DMA_DST*DATA_W +: 32];
  end

  assign o_fields = f;

endmodule

// File: rtl/nn_cfg_bank.sv
// Double-buffered NN config bank with job FSM, one-deep pending start, abort, irq and error.
// Define NN_CFG_RDBK_EN to build the register/status read port; otherwise it is tied off.
module nn_cfg_bank
  import nn_cfg_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 8
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_wr_en,
  input  logic [ADDR_W-1:0]                i_addr,
  input  logic [DATA_W-1:0]                i_wr_data,
  input  logic                             i_rd_en,
  output logic [DATA_W-1:0]                o_rd_data,
  output logic                             o_rd_valid,
  output logic [(NUM_REGS-1)*DATA_W-1:0]   o_cfg,
  output logic                             o_start,
  output logic                             o_abort,
  input  logic                             i_done,
  output logic                             o_busy,
  output logic                             o_irq,
  output logic                             o_err
);

  localparam int          NUM_CFG   = NUM_REGS - 1;
  localparam logic [31:0] CTRL_ADDR = 32'(NUM_REGS - 1);
  localparam logic [31:0] REG_END   = 32'(NUM_REGS);

  state_e            state_q, state_d;
  logic              pending_q, pending_d;
  logic              irq_q, irq_d;
  logic              err_q, err_d;
  logic              start_q, start_d;
  logic              abort_q, abort_d;
  logic [DATA_W-1:0] stg_q [NUM_CFG];
  logic [DATA_W-1:0] stg_d [NUM_CFG];
  logic [DATA_W-1:0] act_q [NUM_CFG];
  logic [DATA_W-1:0] act_d [NUM_CFG];

  logic [31:0] addr_ext;
  logic        cfg_hit, ctrl_hit, oob_hit;
  logic        ctrl_wr, start_cmd, abort_cmd;
  logic        irq_set, err_set, rd_oob, busy;

  assign addr_ext  = 32'(i_addr);
  assign cfg_hit   = addr_ext < CTRL_ADDR;
  assign ctrl_hit  = addr_ext == CTRL_ADDR;
  assign oob_hit   = addr_ext >= REG_END;
  assign ctrl_wr   = i_wr_en && ctrl_hit;
  assign abort_cmd = ctrl_wr && i_wr_data[CTRL_ABORT];
  assign start_cmd = ctrl_wr && i_wr_data[CTRL_START] && !i_wr_data[CTRL_ABORT];
  assign busy      = state_q != ST_IDLE;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    start_d   = 1'b0;
    abort_d   = 1'b0;
    irq_set   = 1'b0;
    err_set   = (i_wr_en && oob_hit) || rd_oob;
    irq_d     = irq_q;
    err_d     = err_q;
    stg_d     = stg_q;
    act_d     = act_q;

    for (int k = 0; k < NUM_CFG; k++) begin
      if (i_wr_en && cfg_hit && addr_ext == 32'(k)) stg_d[k] = i_wr_data;
    end

    if (abort_cmd) begin
      state_d   = ST_IDLE;
      pending_d = 1'b0;
      abort_d   = busy;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_cmd) state_d = ST_COMMIT;
        end
        ST_COMMIT: begin
          act_d   = stg_q;
          state_d = ST_RUN;
          start_d = 1'b1;
          irq_d   = 1'b0;
          if (start_cmd) begin
            if (pending_q) err_set = 1'b1;
            else           pending_d = 1'b1;
          end
        end
        ST_RUN: begin
          // A START landing with done counts as already queued, so chain straight on.
          if (i_done) begin
            irq_set = 1'b1;
            if (start_cmd && pending_q) err_set = 1'b1;
            if (pending_q || start_cmd) begin
              state_d   = ST_COMMIT;
              pending_d = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (start_cmd) begin
            if (pending_q) err_set = 1'b1;
            else           pending_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (ctrl_wr && i_wr_data[CTRL_IRQ_CLR]) irq_d = 1'b0;
    if (irq_set)                            irq_d = 1'b1;
    if (ctrl_wr && i_wr_data[CTRL_ERR_CLR]) err_d = 1'b0;
    if (err_set)                            err_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
      abort_q   <= 1'b0;
      stg_q     <= '{default: '0};
      act_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
      err_q     <= err_d;
      start_q   <= start_d;
      abort_q   <= abort_d;
      stg_q     <= stg_d;
      act_q     <= act_d;
    end
  end

`ifdef NN_CFG_RDBK_EN
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  assign rd_oob = i_rd_en && oob_hit;

  always_comb begin
    rd_valid_d = i_rd_en;
    rd_data_d  = '0;
    if (i_rd_en && cfg_hit) begin
      for (int k = 0; k < NUM_CFG; k++) begin
        if (addr_ext == 32'(k)) rd_data_d = stg_q[k];
      end
    end else if (i_rd_en && ctrl_hit) begin
      rd_data_d = DATA_W'(pack_status(state_q, pending_q, err_q, irq_q, busy));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign o_rd_data  = rd_data_q;
  assign o_rd_valid = rd_valid_q;
`else
  logic unused_rd_en;

  assign unused_rd_en = i_rd_en;
  assign rd_oob       = 1'b0;
  assign o_rd_data    = '0;
  assign o_rd_valid   = 1'b0;
`endif

  for (genvar k = 0; k < NUM_CFG; k++) begin : g_cfg_out
    assign o_cfg[k*DATA_W +: DATA_W] = act_q[k];
  end

  // Named-field view for engine-side consumers; nothing inside the bank reads it.
  logic [FIELDS_W-1:0] unused_eng_fields;

  nn_cfg_decode #(
    .DATA_W  (DATA_W),
    .NUM_CFG (NUM_CFG)
  ) u_decode (
    .i_cfg    (o_cfg),
    .o_fields (unused_eng_fields)
  );

  assign o_start = start_q;
  assign o_abort = abort_q;
  assign o_busy  = busy;
  assign o_irq   = irq_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_nn_cfg_bank.sv
// Directed self-checking bench for nn_cfg_bank; read expectations follow NN_CFG_RDBK_EN.
module tb_nn_cfg_bank;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 8;
  localparam int CFG_W    = (NUM_REGS - 1) * DATA_W;

`ifdef NN_CFG_RDBK_EN
  localparam bit RDBK = 1'b1;
`else
  localparam bit RDBK = 1'b0;
`endif

  logic              clk;
  logic              i_rst;
  logic              i_wr_en;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_wr_data;
  logic              i_rd_en;
  logic [DATA_W-1:0] o_rd_data;
  logic              o_rd_valid;
  logic [CFG_W-1:0]  o_cfg;
  logic              o_start;
  logic              o_abort;
  logic              i_done;
  logic              o_busy;
  logic              o_irq;
  logic              o_err;

  int nVectors     = 0;
  int nMiscompares = 0;

  nn_cfg_bank #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_wr_en    (i_wr_en),
    .i_addr     (i_addr),
    .i_wr_data  (i_wr_data),
    .i_rd_en    (i_rd_en),
    .o_rd_data  (o_rd_data),
    .o_rd_valid (o_rd_valid),
    .o_cfg      (o_cfg),
    .o_start    (o_start),
    .o_abort    (o_abort),
    .i_done     (i_done),
    .o_busy     (o_busy),
    .o_irq      (o_irq),
    .o_err      (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVectors++;
    if (obs !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic applyStimulus(input logic wr, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] data, input logic rd, input logic done);
    i_wr_en   = wr;
    i_addr    = addr;
    i_wr_data = data;
    i_rd_en   = rd;
    i_done    = done;
    @(posedge clk);
    #1;
    i_wr_en   = 1'b0;
    i_addr    = '0;
    i_wr_data = '0;
    i_rd_en   = 1'b0;
    i_done    = 1'b0;
  endtask

  task automatic wrReg(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    applyStimulus(1'b1, addr, data, 1'b0, 1'b0);
  endtask

  task automatic rdReg(input logic [ADDR_W-1:0] addr);
    applyStimulus(1'b0, addr, '0, 1'b1, 1'b0);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] cfgWord(input int k);
    return o_cfg[k*DATA_W +: DATA_W];
  endfunction

  function automatic logic [31:0] rdExp(input logic [31:0] v);
    return RDBK ? v : 32'h0;
  endfunction

  function automatic logic [31:0] flags();
    return {27'b0, o_start, o_abort, o_busy, o_irq, o_err};
  endfunction

  initial begin
    i_rst = 1'b1; i_wr_en = 1'b0; i_addr = '0; i_wr_data = '0; i_rd_en = 1'b0; i_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_flags", flags(), 32'h0);
    checkOutput("reset_rd_valid", 32'(o_rd_valid), 32'h0);
    checkOutput("reset_rd_data", o_rd_data, 32'h0);
    checkOutput("reset_cfg0", cfgWord(0), 32'h0);
    i_rst = 1'b0;

    // Staging write does not reach active config until a commit
    wrReg(4'd0, 32'hC1234567);
    checkOutput("t1_cfg0_staged_only", cfgWord(0), 32'h0);
    rdReg(4'd0);
    checkOutput("t1_rd_stage0", o_rd_data, rdExp(32'hC1234567));
    checkOutput("t1_rd_valid", 32'(o_rd_valid), 32'(RDBK));
    wrReg(4'd7, 32'h1);
    checkOutput("t1_start_commit_cycle", 32'(o_start), 32'h0);
    checkOutput("t1_busy_commit", 32'(o_busy), 32'h1);
    checkOutput("t1_cfg0_commit_cycle", cfgWord(0), 32'h0);
    idleCycle();
    checkOutput("t1_start_pulse", 32'(o_start), 32'h1);
    checkOutput("t1_cfg0_active", cfgWord(0), 32'hC1234567);
    checkOutput("t1_busy_run", 32'(o_busy), 32'h1);
    idleCycle();
    checkOutput("t1_start_one_cycle", 32'(o_start), 32'h0);

    // Queued start chains into a second job on done
    wrReg(4'd2, 32'hA0);
    checkOutput("t2_cfg2_not_active", cfgWord(2), 32'h0);
    wrReg(4'd7, 32'h1);
    rdReg(4'd7);
    checkOutput("t2_status_pending", o_rd_data, rdExp(32'h29));
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    checkOutput("t2_irq_on_done", 32'(o_irq), 32'h1);
    checkOutput("t2_busy_commit", 32'(o_busy), 32'h1);
    checkOutput("t2_no_start_yet", 32'(o_start), 32'h0);
    idleCycle();
    checkOutput("t2_second_start", 32'(o_start), 32'h1);
    checkOutput("t2_cfg2_active", cfgWord(2), 32'hA0);
    checkOutput("t2_irq_cleared_by_commit", 32'(o_irq), 32'h0);
    rdReg(4'd7);
    checkOutput("t2_status_run", o_rd_data, rdExp(32'h21));

    // Overflowing the pending slot flags an error; ERR_CLR leaves the job alone
    wrReg(4'd7, 32'h1);
    checkOutput("t3_err_first_start", 32'(o_err), 32'h0);
    wrReg(4'd7, 32'h1);
    checkOutput("t3_err_second_start", 32'(o_err), 32'h1);
    rdReg(4'd7);
    checkOutput("t3_status_err", o_rd_data, rdExp(32'h2D));
    wrReg(4'd7, 32'h8);
    checkOutput("t3_err_cleared", 32'(o_err), 32'h0);
    checkOutput("t3_busy_kept", 32'(o_busy), 32'h1);
    rdReg(4'd7);
    checkOutput("t3_status_after_clr", o_rd_data, rdExp(32'h29));

    // Abort from RUN with a pending start
    wrReg(4'd7, 32'h2);
    checkOutput("t4_abort_pulse", 32'(o_abort), 32'h1);
    checkOutput("t4_busy_low", 32'(o_busy), 32'h0);
    checkOutput("t4_irq_unchanged", 32'(o_irq), 32'h0);
    idleCycle();
    checkOutput("t4_abort_one_cycle", 32'(o_abort), 32'h0);
    rdReg(4'd7);
    checkOutput("t4_status_idle", o_rd_data, rdExp(32'h0));
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    checkOutput("t4_done_idle_no_irq", flags(), 32'h0);
    checkOutput("t4_cfg2_kept", cfgWord(2), 32'hA0);
    wrReg(4'd7, 32'h2);
    checkOutput("t4_abort_idle_no_pulse", 32'(o_abort), 32'h0);

    // Single job to completion raises irq; IRQ_CLR drops it
    wrReg(4'd7, 32'h1);
    idleCycle();
    idleCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    checkOutput("irq_done_flags", flags(), 32'h2);
    rdReg(4'd7);
    checkOutput("irq_status", o_rd_data, rdExp(32'h02));
    wrReg(4'd7, 32'h4);
    checkOutput("irq_clear", 32'(o_irq), 32'h0);

    // done and IRQ_CLR together: the set wins
    wrReg(4'd7, 32'h1);
    idleCycle();
    applyStimulus(1'b1, 4'd7, 32'h4, 1'b0, 1'b1);
    checkOutput("irq_set_wins", flags(), 32'h2);

    // START and done together with nothing queued go straight to COMMIT
    wrReg(4'd7, 32'h1);
    idleCycle();
    checkOutput("sd_irq_cleared", 32'(o_irq), 32'h0);
    applyStimulus(1'b1, 4'd7, 32'h1, 1'b0, 1'b1);
    checkOutput("sd_commit_flags", flags(), 32'h6);
    idleCycle();
    checkOutput("sd_restart", 32'(o_start), 32'h1);
    rdReg(4'd7);
    checkOutput("sd_status", o_rd_data, rdExp(32'h21));

    // Error set coinciding with ERR_CLR: the set wins
    wrReg(4'd7, 32'h1);
    applyStimulus(1'b1, 4'd7, 32'h9, 1'b0, 1'b0);
    checkOutput("err_set_wins", 32'(o_err), 32'h1);
    wrReg(4'd7, 32'h8);
    wrReg(4'd7, 32'h2);
    idleCycle();

    // Out-of-range accesses
    wrReg(4'd9, 32'hFFFFFFFF);
    checkOutput("t5_oob_wr_err", 32'(o_err), 32'h1);
    checkOutput("t5_cfg0_unchanged", cfgWord(0), 32'hC1234567);
    checkOutput("t5_cfg1_unchanged", cfgWord(1), 32'h0);
    rdReg(4'd1);
    checkOutput("t5_stage1_unchanged", o_rd_data, 32'h0);
    wrReg(4'd7, 32'h8);
    rdReg(4'd9);
    checkOutput("t5_oob_rd_data", o_rd_data, 32'h0);
    checkOutput("t5_oob_rd_valid", 32'(o_rd_valid), 32'(RDBK));
    checkOutput("t5_oob_rd_err", 32'(o_err), 32'(RDBK));
    wrReg(4'd7, 32'h8);

    // Staging write in the COMMIT cycle misses this job's snapshot
    wrReg(4'd1, 32'h11);
    wrReg(4'd7, 32'h1);
    applyStimulus(1'b1, 4'd1, 32'h22, 1'b0, 1'b0);
    checkOutput("cw_start", 32'(o_start), 32'h1);
    checkOutput("cw_cfg1_prewrite", cfgWord(1), 32'h11);
    rdReg(4'd1);
    checkOutput("cw_stage1_new", o_rd_data, rdExp(32'h22));

    // Reset mid-job
    i_rst = 1'b1;
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    checkOutput("t6_flags", flags(), 32'h0);
    checkOutput("t6_cfg0", cfgWord(0), 32'h0);
    checkOutput("t6_cfg1", cfgWord(1), 32'h0);
    rdReg(4'd7);
    checkOutput("t6_status", o_rd_data, 32'h0);
    rdReg(4'd0);
    checkOutput("t6_stage0", o_rd_data, 32'h0);
    wrReg(4'd0, 32'h5);
    wrReg(4'd7, 32'h1);
    idleCycle();
    checkOutput("t6_restart", 32'(o_start), 32'h1);
    checkOutput("t6_cfg0_new", cfgWord(0), 32'h5);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
